// File: rtl/vdcm_fetch_pkg.sv
// Shared types and helpers for the substream bitstream fetch block.
//   NUM_SSM       : number of substream parsers served per cycle
//   FETCH_DW      : default bitstream word width
//   fetch_state_e : IDLE / FILL / RUN start-up sequence
//   rank4()       : position of SSM k among this cycle's requests
package vdcm_fetch_pkg;

  localparam int NUM_SSM  = 4;
  localparam int FETCH_DW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } fetch_state_e;

  // Number of lower-numbered SSMs also requesting this cycle; this is the
  // offset from the read pointer of the word SSM k receives.
  function automatic logic [2:0] rank4(input logic [NUM_SSM-1:0] rd_en, input int k);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      if (i < k && rd_en[i]) r = r + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ssm_fifo_mem.sv
// DEPTH x DW register array for the fetch FIFO.
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the clock edge
//   rd_addr : one address per SSM read port
//   rd_data : asynchronous read data, one word per SSM port
// Storage has no reset; the top only exposes words below the fill level.
module ssm_fifo_mem
  import vdcm_fetch_pkg::*;
#(
  parameter int DW    = FETCH_DW,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [AW-1:0]                    wr_addr,
  input  logic [DW-1:0]                    wr_data,
  input  logic [NUM_SSM-1:0][AW-1:0]       rd_addr,
  output logic [NUM_SSM-1:0][DW-1:0]       rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar g = 0; g < NUM_SSM; g++) begin : g_rd
    assign rd_data[g] = mem_q[rd_addr[g]];
  end

endmodule

// File: rtl/ssm_bit_fetch.sv
// Bitstream word feeder for the four substream parsers (SSM0..SSM3).
// Buffers DW-bit words in a DEPTH-word FIFO and serves up to four same-cycle
// read requests in SSM order with zero latency. Decoding starts once PREFILL
// words are buffered: start_dec for SSM0, start_dec_ff one cycle later for
// SSM1-3.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : arms the start sequence
//   flush               : one-cycle pulse, empties FIFO and returns to IDLE
//   in_data/in_vld/in_rdy : word input handshake
//   rd_en[3:0]          : per-SSM read request
//   rd_data_0..3        : word for each SSM, valid with rd_en
//   start_dec/_ff       : parser starts
//   level               : words held
//   err_underflow       : sticky, more requests than words in RUN
//   err_early_rd        : sticky, request outside RUN
//   ssm_cnt_0..3        : words served per SSM
// Build option: define SSM_FETCH_CNT_EN to implement the per-SSM served-word
// counters; otherwise ssm_cnt_* are constant zero.
module ssm_bit_fetch
  import vdcm_fetch_pkg::*;
#(
  parameter int DW      = FETCH_DW,
  parameter int DEPTH   = 16,
  parameter int PREFILL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [DW-1:0]             in_data,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [3:0]                rd_en,
  output logic [DW-1:0]             rd_data_0,
  output logic [DW-1:0]             rd_data_1,
  output logic [DW-1:0]             rd_data_2,
  output logic [DW-1:0]             rd_data_3,
  output logic                      start_dec,
  output logic                      start_dec_ff,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      err_underflow,
  output logic                      err_early_rd,
  output logic [15:0]               ssm_cnt_0,
  output logic [15:0]               ssm_cnt_1,
  output logic [15:0]               ssm_cnt_2,
  output logic [15:0]               ssm_cnt_3
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  fetch_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          start_dec_q, start_dec_d;
  logic          start_dec_ff_q, start_dec_ff_d;
  logic          err_underflow_q, err_underflow_d;
  logic          err_early_rd_q, err_early_rd_d;

  logic                        is_run;
  logic                        push;
  logic [2:0]                  n_req;
  logic [LW-1:0]               n_pop;
  logic [NUM_SSM-1:0][2:0]     rank;
  logic [NUM_SSM-1:0]          avail;
  logic [NUM_SSM-1:0][AW-1:0]  rd_addr;
  logic [NUM_SSM-1:0][DW-1:0]  mem_rd;

  assign is_run = (state_q == RUN);
  // No credit for a same-cycle pop: readiness follows the held level only.
  assign in_rdy = (level_q < LW'(DEPTH));
  assign push   = in_vld & in_rdy;

  // Per-SSM slot: a word exists for SSM k only if its rank is below level.
  always_comb begin
    n_req = '0;
    for (int k = 0; k < NUM_SSM; k++) begin
      rank[k]    = rank4(rd_en, k);
      rd_addr[k] = rd_ptr_q + AW'(rank[k]);
      avail[k]   = is_run && (LW'(rank[k]) < level_q);
      n_req      = n_req + 3'(rd_en[k]);
    end
    // Underflow pops only what is held.
    if (!is_run)                  n_pop = '0;
    else if (LW'(n_req) > level_q) n_pop = level_q;
    else                          n_pop = LW'(n_req);
  end

  assign rd_data_0 = avail[0] ? mem_rd[0] : '0;
  assign rd_data_1 = avail[1] ? mem_rd[1] : '0;
  assign rd_data_2 = avail[2] ? mem_rd[2] : '0;
  assign rd_data_3 = avail[3] ? mem_rd[3] : '0;

  ssm_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push & ~flush),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (mem_rd)
  );

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    start_dec_d     = start_dec_q;
    start_dec_ff_d  = start_dec_ff_q;
    err_underflow_d = err_underflow_q;
    err_early_rd_d  = err_early_rd_q;

    if (flush) begin
      // Flush overrides push/pop; any word offered this cycle is dropped.
      state_d        = IDLE;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      level_d        = '0;
      start_dec_d    = 1'b0;
      start_dec_ff_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      rd_ptr_d = rd_ptr_q + n_pop[AW-1:0];
      level_d  = level_q + LW'(push) - n_pop;
      unique case (state_q)
        IDLE:    if (enable) state_d = FILL;
        FILL:    if (level_q >= LW'(PREFILL)) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
      start_dec_d    = (state_d == RUN);
      start_dec_ff_d = start_dec_q;
    end

    if (is_run && (LW'(n_req) > level_q)) err_underflow_d = 1'b1;
    if (!is_run && (rd_en != '0))        err_early_rd_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      start_dec_q     <= 1'b0;
      start_dec_ff_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_early_rd_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      start_dec_q     <= start_dec_d;
      start_dec_ff_q  <= start_dec_ff_d;
      err_underflow_q <= err_underflow_d;
      err_early_rd_q  <= err_early_rd_d;
    end
  end

  assign level         = level_q;
  assign start_dec     = start_dec_q;
  assign start_dec_ff  = start_dec_ff_q;
  assign err_underflow = err_underflow_q;
  assign err_early_rd  = err_early_rd_q;

`ifdef SSM_FETCH_CNT_EN
  logic [NUM_SSM-1:0][15:0] cnt_q, cnt_d;

  // Count only words actually delivered; saturate rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_SSM; k++) begin
      if (flush)                                             cnt_d[k] = '0;
      else if (rd_en[k] && avail[k] && cnt_q[k] != 16'hFFFF) cnt_d[k] = cnt_q[k] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign ssm_cnt_0 = cnt_q[0];
  assign ssm_cnt_1 = cnt_q[1];
  assign ssm_cnt_2 = cnt_q[2];
  assign ssm_cnt_3 = cnt_q[3];
`else
  assign ssm_cnt_0 = '0;
  assign ssm_cnt_1 = '0;
  assign ssm_cnt_2 = '0;
  assign ssm_cnt_3 = '0;
`endif

endmodule
